ppe_mac_sequencer: RTL
======================

Name: ppe_mac_sequencer

Overview:
- Clocked controller that sequences one partial PE (PPE).
- Accepts depacketized commands, loads weights into the external weight RF and input rows into the external input RF, runs FILTER_SIZE-tap multiply-accumulate windows across each row, and emits partial sums to the packetizer.
- Destination SPEs are visited round-robin. After each row except the last, a refill request goes to IMEM.
- Sits between the PPE depacketizer/packetizer and the two register files.

Parameters:
- FILTER_SIZE, 5, taps per window; also the number of SPEs.
- IFMAP_SIZE, 25, inputs per row.
- WEIGHT_WIDTH, 8, unsigned weight width.
- SUM_WIDTH, 13, partial sum register is SUM_WIDTH+1 bits.
- PE_ID, 0, placed in the opcode field of every outgoing packet.
- IMEM_ID, 11, destination address of refill requests.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid&ready
- cmd_opcode  in  4  0=weights, 1=input row, 15=timestep done
- cmd_data  in  25  payload
- wrf_we  out  1  weight RF write enable
- wrf_waddr  out  3  weight RF write address
- wrf_wdata  out  8  weight RF write data
- wrf_raddr  out  3  weight RF read address; wrf_rdata valid the next cycle
- wrf_rdata  in  8  weight read data
- irf_we  out  1  input RF row write enable
- irf_wdata  out  25  input row
- irf_raddr  out  5  input RF bit address; irf_rdata valid the next cycle
- irf_rdata  in  1  input bit
- out_valid  out  1  packet valid
- out_ready  in  1  packetizer ready
- out_dest  out  4  packet destination address
- out_opcode  out  4  packet opcode field
- out_data  out  25  packet data
- ts  out  2  current timestep
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low at a clk edge) takes priority over everything, including mid-row.
  - State goes to IDLE.
  - All outputs go to 0 except ts=1.
  - Internal registers: wptr=0, row_cnt=0, dest_pe=0, win=0, tap=0, acc=0.
  - Any in-flight packet is dropped.
- cmd_ready is 1 only in IDLE. The command is captured on the accepting edge.
- FSM states: IDLE, WLOAD, ILOAD, MAC, EMIT, REQ.
- Opcode 0 (weights): go to WLOAD for 3 cycles.
  - Cycle i (i=0..2): wrf_we=1, wrf_waddr=wptr+i, wrf_wdata=cmd_data[8i+7:8i].
  - Then wptr toggles between 0 and 3, and the FSM returns to IDLE.
- Opcode 1 (input row): go to ILOAD for 1 cycle.
  - irf_we=1, irf_wdata=cmd_data.
  - row_cnt increments, saturating at 21.
  - win=0, then go to MAC.
- MAC state, FILTER_SIZE+1 cycles per window:
  - Cycles 0..4 drive wrf_raddr=tap and irf_raddr=win+tap.
  - On cycles 1..5, if irf_rdata=1, acc += zero-extended wrf_rdata.
  - acc is cleared when each window starts. Maximum value is 1275, so no overflow.
  - Then go to EMIT.
- EMIT state:
  - out_valid=1, out_dest=dest_pe, out_opcode=PE_ID, out_data=zero-extended acc.
  - All fields are held stable until out_valid&out_ready.
  - On transfer: dest_pe=(dest_pe+1) mod FILTER_SIZE, win++.
  - If win reaches 21 (IFMAP_SIZE-FILTER_SIZE+1), go to REQ if row_cnt<21, else to IDLE. Otherwise start the next MAC.
- REQ state:
  - out_valid=1, out_dest=IMEM_ID, out_opcode=PE_ID, out_data=0.
  - Held until ready, then go to IDLE.
- Opcode 15 (timestep done): ts=2, row_cnt=0, dest_pe=0. Weights and wptr are unchanged. One cycle, then IDLE.
- Any other opcode is consumed and ignored with no state change.
- dest_pe persists across rows within a timestep.
- Latency: with out_ready held 1, one row takes 1+21×7+1=149 cycles from accept to IDLE. Each backpressure cycle adds one cycle.
- A row with row_cnt=21 still produces 21 sums but no IMEM request.
- out_valid never drops without a transfer, except on reset.

Test Plan:
- Reset -> ts=1; all other outputs 0; cmd_ready=1 the cycle after reset is released.
- Weights 0x030201 then 0x000504 -> writes (0,1),(1,2),(2,3),(3,4),(4,5),(5,0) in 6 consecutive WLOAD cycles; wptr returns to 0.
- Input row 0x1FFFFFF, out_ready=1 -> 21 packets with data 15 and dests 0,1,2,3,4,0,…; then dest=11, opcode=PE_ID, data=0; IDLE after 149 cycles.
- Input 0x0000021 (bits 0 and 5) -> window 0=1, window 1=5, window 2=4, window 3=3, window 4=2, window 5=1, windows 6..20=0.
- out_ready low for 10 cycles during window 3 -> fields held stable; no duplicate or lost packet; total latency 159 cycles.
- Feed 21 rows, then opcode 15 -> 21st row emits no IMEM request; ts=2; the next row starts at dest 0. Assert rst_n low mid-MAC -> out_valid=0 next cycle, state IDLE.

Source files
------------

// File: rtl/ppe_mac_sequencer.sv
// Sequencer for one partial PE: loads weight/input register files, runs
// FILTER_SIZE-tap MAC windows across each input row and emits partial sums.
module ppe_mac_sequencer #(
  parameter int FILTER_SIZE  = 5,
  parameter int IFMAP_SIZE   = 25,
  parameter int WEIGHT_WIDTH = 8,
  parameter int SUM_WIDTH    = 13,
  parameter int PE_ID        = 0,
  parameter int IMEM_ID      = 11
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_opcode,
  input  logic [IFMAP_SIZE-1:0]   cmd_data,
  output logic                    wrf_we,
  output logic [2:0]              wrf_waddr,
  output logic [WEIGHT_WIDTH-1:0] wrf_wdata,
  output logic [2:0]              wrf_raddr,
  input  logic [WEIGHT_WIDTH-1:0] wrf_rdata,
  output logic                    irf_we,
  output logic [IFMAP_SIZE-1:0]   irf_wdata,
  output logic [4:0]              irf_raddr,
  input  logic                    irf_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              out_dest,
  output logic [3:0]              out_opcode,
  output logic [IFMAP_SIZE-1:0]   out_data,
  output logic [1:0]              ts,
  output logic                    busy,
  output logic [2:0]              dbg_state
);

  // Handshakes: a command transfers on a clk edge where cmd_valid & cmd_ready;
  // a packet transfers where out_valid & out_ready. Once out_valid rises, it and
  // all out_* fields hold until the transfer (only reset can withdraw them).

  typedef enum logic [2:0] {IDLE, WLOAD, ILOAD, MAC, EMIT, REQ} state_t;

  localparam logic [2:0] LAST_TAP  = 3'(FILTER_SIZE);
  localparam logic [2:0] DEST_LAST = 3'(FILTER_SIZE - 1);
  localparam logic [4:0] LAST_WIN  = 5'(IFMAP_SIZE - FILTER_SIZE);
  localparam logic [4:0] ROW_LIMIT = 5'(IFMAP_SIZE - FILTER_SIZE + 1);
  localparam logic [1:0] WL_LAST   = 2'd2;

  state_t                  state, state_next;
  logic [IFMAP_SIZE-1:0]   cmd_q;
  logic [2:0]              wptr;
  logic [1:0]              wcnt;
  logic [4:0]              row_cnt;
  logic [2:0]              dest_pe;
  logic [4:0]              win;
  logic [2:0]              tap;
  logic [SUM_WIDTH:0]      acc;
  logic [1:0]              ts_q;

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wrf_we     = 1'b0;
    wrf_waddr  = '0;
    wrf_wdata  = '0;
    wrf_raddr  = '0;
    irf_we     = 1'b0;
    irf_wdata  = '0;
    irf_raddr  = '0;
    out_valid  = 1'b0;
    out_dest   = '0;
    out_opcode = '0;
    out_data   = '0;
    case (state)
      IDLE: begin
        cmd_ready = rst_n;
        if (cmd_valid) begin
          case (cmd_opcode)
            4'd0:    state_next = WLOAD;
            4'd1:    state_next = ILOAD;
            default: state_next = IDLE;
          endcase
        end
      end
      WLOAD: begin
        wrf_we    = 1'b1;
        wrf_waddr = wptr + {1'b0, wcnt};
        wrf_wdata = cmd_q[{wcnt, 3'b000} +: WEIGHT_WIDTH];
        if (wcnt == WL_LAST) state_next = IDLE;
      end
      ILOAD: begin
        irf_we     = 1'b1;
        irf_wdata  = cmd_q;
        state_next = MAC;
      end
      MAC: begin
        // Reads are issued on taps 0..4; data arrives one cycle later.
        if (tap != LAST_TAP) begin
          wrf_raddr = tap;
          irf_raddr = win + {2'b00, tap};
        end else begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid  = 1'b1;
        out_dest   = {1'b0, dest_pe};
        out_opcode = 4'(PE_ID);
        out_data   = {{(IFMAP_SIZE-SUM_WIDTH-1){1'b0}}, acc};
        if (out_ready) begin
          if (win == LAST_WIN) state_next = (row_cnt < ROW_LIMIT) ? REQ : IDLE;
          else                 state_next = MAC;
        end
      end
      REQ: begin
        out_valid  = 1'b1;
        out_dest   = 4'(IMEM_ID);
        out_opcode = 4'(PE_ID);
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cmd_q   <= '0;
      wptr    <= '0;
      wcnt    <= '0;
      row_cnt <= '0;
      dest_pe <= '0;
      win     <= '0;
      tap     <= '0;
      acc     <= '0;
      ts_q    <= 2'd1;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd_data;
            wcnt  <= '0;
            if (cmd_opcode == 4'd15) begin
              ts_q    <= 2'd2;
              row_cnt <= '0;
              dest_pe <= '0;
            end
          end
        end
        WLOAD: begin
          wcnt <= wcnt + 2'd1;
          // Weight banks alternate between addresses 0..2 and 3..5.
          if (wcnt == WL_LAST) wptr <= (wptr == 3'd0) ? 3'd3 : 3'd0;
        end
        ILOAD: begin
          if (row_cnt != ROW_LIMIT) row_cnt <= row_cnt + 5'd1;
          win <= '0;
          tap <= '0;
          acc <= '0;
        end
        MAC: begin
          tap <= (tap == LAST_TAP) ? 3'd0 : tap + 3'd1;
          if (tap != 3'd0 && irf_rdata) acc <= acc + (SUM_WIDTH+1)'(wrf_rdata);
        end
        EMIT: begin
          if (out_ready) begin
            dest_pe <= (dest_pe == DEST_LAST) ? 3'd0 : dest_pe + 3'd1;
            win     <= win + 5'd1;
            tap     <= '0;
            acc     <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign ts        = ts_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
